// File: rtl/aes_pkg.sv
// Shared constants and types for the iterative AES-128 round scheduler.
package aes_pkg;

  localparam int NR = 10;
  localparam int BW = 128;

  typedef enum logic {
    AES_ENC = 1'b0,
    AES_DEC = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/aes_key_sel.sv
// Round-key mux: forward index for encrypt, reverse index for decrypt,
// key0 whenever no round is in progress.
module aes_key_sel
  import aes_pkg::*;
(
  input  logic [BW*(NR+1)-1:0] round_keys,
  input  logic [3:0]           round,
  input  mode_t                mode,
  input  logic                 active,
  output logic [BW-1:0]        key
);

  logic [3:0] idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
    if (active) begin
      idx = (mode == AES_DEC) ? 4'(NR) - round : round;
    end
    key = round_keys[BW*idx +: BW];
  end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES-128 scheduler: accepts a block, drives an external round unit
// for NR rounds, then holds the result until the consumer takes it.
module aes_round_sched
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [BW-1:0]        in_data,
  input  logic [BW*(NR+1)-1:0] round_keys,
  output logic [BW-1:0]        rd_state,
  output logic [BW-1:0]        rd_key,
  output logic                 rd_mode,
  output logic                 rd_last,
  input  logic [BW-1:0]        rd_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0]        out_data,
  output logic                 busy,
  output logic [3:0]           round
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t         state_q, state_d;
  mode_t          mode_q;
  logic [BW-1:0]  data_q;
  logic [3:0]     round_q;
  logic           accept;
  logic [BW-1:0]  key_first;

  assign accept = in_valid && (state_q == ST_IDLE);

  // Initial whitening key: key0 going forward, key(NR) going backward.
  assign key_first = (in_mode == AES_DEC) ? round_keys[BW*NR +: BW] : round_keys[BW-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)                 state_d = ST_RUN;
      ST_RUN:  if (round_q == LAST_ROUND)    state_d = ST_DONE;
      ST_DONE: if (out_ready)                state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      round_q <= '0;
      mode_q  <= AES_ENC;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q  <= mode_t'(in_mode);
            data_q  <= in_data ^ key_first;
            round_q <= 4'd1;
          end
        end
        ST_RUN: begin
          data_q <= rd_result;
          if (round_q != LAST_ROUND) round_q <= round_q + 4'd1;
        end
        ST_DONE: begin
          if (out_ready) round_q <= '0;
        end
        default: round_q <= '0;
      endcase
    end
  end

  aes_key_sel u_key_sel (
    .round_keys (round_keys),
    .round      (round_q),
    .mode       (mode_q),
    .active     (state_q == ST_RUN),
    .key        (rd_key)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign rd_state  = data_q;
  assign rd_mode   = mode_q;
  assign rd_last   = (state_q == ST_RUN) && (round_q == LAST_ROUND);
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched with a behavioural AES round unit and
// key expansion; expected blocks are the FIPS-197 C.1 constants.
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int BW = 128;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ALT = 128'hdeadbeefcafef00d0123456789abcdef;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [BW-1:0]        in_data;
  logic [BW*(NR+1)-1:0] round_keys;
  logic [BW-1:0]        rd_state;
  logic [BW-1:0]        rd_key;
  logic                 rd_mode;
  logic                 rd_last;
  logic [BW-1:0]        rd_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [BW-1:0]        out_data;
  logic                 busy;
  logic [3:0]           round;

  logic [127:0] rk [NR+1];
  int vectors = 0;
  int errors  = 0;

  aes_round_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .round_keys (round_keys),
    .rd_state   (rd_state),
    .rd_key     (rd_key),
    .rd_mode    (rd_mode),
    .rd_last    (rd_last),
    .rd_result  (rd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .round      (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural AES round unit ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] k,
                                            input logic dec, input logic last);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = dec ? inv_sbox(s[r+4*((c-r+4)%4)]) : sbox(s[r+4*((c+r)%4)]);
    if (dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (dec) begin
          t[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          t[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          t[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          t[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end else begin
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
    end
    if (!dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res;
  endfunction

  assign rd_result = round_fn(rd_state, rd_key, rd_mode, rd_last);

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= NR; k++) begin
      rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      round_keys[BW*k +: BW] = rk[k];
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int t_out [2];
    logic [127:0] d_out [2];
    logic m_out [2];
    int n_out;
    logic prev_ready;
    logic seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    round_keys = '0;
    expand_key(KEY);
    #22 rst = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_round", 128'(round), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_rd_key", rd_key, KEY);
    check("rst_rd_last", 128'(rd_last), 128'(0));

    // FIPS-197 C.1 encrypt with latency
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT;
    tick();
    in_valid = 1'b0;
    check("enc_round1", 128'(round), 128'(1));
    wait_done(n);
    check("enc_latency", 128'(n), 128'(10));
    check("enc_data", out_data, CT);
    check("enc_done_round", 128'(round), 128'(10));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("enc_idle", 128'(in_ready), 128'(1));
    check("enc_idle_round", 128'(round), 128'(0));

    // Decrypt, walking the key schedule backwards
    in_valid = 1'b1; in_mode = 1'b1; in_data = CT;
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= NR; r++) begin
      check($sformatf("dec_key_r%0d", r), rd_key, rk[NR-r]);
      check($sformatf("dec_last_r%0d", r), 128'(rd_last), 128'(r == NR));
      tick();
    end
    check("dec_valid", 128'(out_valid), 128'(1));
    check("dec_data", out_data, PT);
    check("done_rd_key", rd_key, rk[0]);

    // Backpressure: result held, second request ignored while DONE
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'(1));
      check($sformatf("bp_ready_%0d", i), 128'(in_ready), 128'(0));
      check($sformatf("bp_data_%0d", i), out_data, PT);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_idle", 128'(in_ready), 128'(1));
    check("bp_hs_round", 128'(round), 128'(0));
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", 128'(busy), 128'(1));
    check("bp_next_round", 128'(round), 128'(1));
    check("bp_next_mode", 128'(rd_mode), 128'(0));
    wait_done(n);
    check("bp_latency", 128'(n), 128'(10));
    check("bp_data", out_data, CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back encrypt then decrypt with handshakes held high
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT; out_ready = 1'b1;
    tick();
    in_mode = 1'b1; in_data = CT;
    prev_ready = 1'b0;
    n_out = 0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (prev_ready && busy && in_valid) in_valid = 1'b0;
      if (out_valid) begin
        if (n_out < 2) begin
          t_out[n_out] = c;
          d_out[n_out] = out_data;
          m_out[n_out] = rd_mode;
        end
        n_out++;
      end
      prev_ready = in_ready;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", 128'(n_out), 128'(2));
    check("b2b_first_at", 128'(t_out[0]), 128'(10));
    check("b2b_spacing", 128'(t_out[1] - t_out[0]), 128'(12));
    check("b2b_enc_data", d_out[0], CT);
    check("b2b_dec_data", d_out[1], PT);
    check("b2b_enc_mode", 128'(m_out[0]), 128'(0));
    check("b2b_dec_mode", 128'(m_out[1]), 128'(1));

    // Reset in round 5 of a decrypt
    in_valid = 1'b1; in_mode = 1'b1; in_data = CT;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_round5", 128'(round), 128'(5));
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_round", 128'(round), 128'(0));
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_data", out_data, 128'h0);
    check("mid_rst_mode", 128'(rd_mode), 128'(0));
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_valid", 128'(seen), 128'(0));
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("post_rst_latency", 128'(n), 128'(10));
    check("post_rst_data", out_data, CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Request pulsed during round 3 is ignored
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("run_round3", 128'(round), 128'(3));
    in_valid = 1'b1; in_mode = 1'b1; in_data = ALT;
    check("run_in_ready", 128'(in_ready), 128'(0));
    tick();
    in_valid = 1'b0;
    check("run_round4", 128'(round), 128'(4));
    check("run_mode_kept", 128'(rd_mode), 128'(0));
    wait_done(n);
    check("run_latency", 128'(n), 128'(7));
    check("run_data", out_data, CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("run_idle", 128'(in_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative AES-128 round scheduler. It accepts one 128-bit block and a mode (encrypt/decrypt) over a valid/ready handshake. It then drives one shared combinational round unit for NR rounds, selecting the correct round key from a precomputed key-schedule bus, and presents the result on a valid/ready output. It replaces free-running per-round counting at the top level with an explicit start/busy/done sequence that both cipher and decipher traffic share.

## Interface
- NR, 10, number of rounds; key bus carries NR+1 round keys
- BW, 128, block and round-key width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  scheduler can accept (high only in IDLE)
- in_mode  in  1  0 = encrypt, 1 = decrypt
- in_data  in  BW  plaintext or ciphertext block
- round_keys  in  BW*(NR+1)  key k at bits [BW*k+BW-1 : BW*k]; must be stable from accept until out handshake
- rd_state  out  BW  current state register to round unit
- rd_key  out  BW  round key for current round
- rd_mode  out  1  latched mode
- rd_last  out  1  high on final round (no MixColumns / InvMixColumns)
- rd_result  in  BW  combinational round-unit output
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  BW  result block (equals state register)
- busy  out  1  high in RUN or DONE
- round  out  4  current round index, 0 in IDLE

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE, state reg = 0, round = 0, mode = 0, out_valid = 0, in_ready = 1, busy = 0.
- IDLE: in_ready = 1. On in_valid & in_ready: latch mode, state <= in_data ^ key0 (encrypt) or in_data ^ key(NR) (decrypt), round <= 1, go to RUN.
- RUN, round r (1..NR): rd_key = key r (encrypt) or key(NR-r) (decrypt); rd_last = (r == NR); state <= rd_result each cycle; round <= r+1. Leave for DONE after r == NR.
- DONE: out_valid = 1, out_data stable, round holds NR. On out_valid & out_ready: go to IDLE, round <= 0. State reg keeps its value (don't-care outside DONE).
- in_valid is ignored outside IDLE; no queueing, and the request is not dropped silently because in_ready is low.
- rd_key and rd_last are don't-care in IDLE/DONE, but are driven: key0 and 0 respectively.
- Round index arithmetic is 4 bits; NR ≤ 14 is legal and no wrap is possible.
- Async rst in any state returns to reset values at once; an in-flight block is discarded and no out_valid is issued.

## Timing
- Accept at edge T, so RUN starts at T+1. Round r is computed in cycle T+r. out_valid rises after edge T+NR, giving a latency of NR cycles (10) from accept to out_valid.
- out_valid & out_ready in cycle D: in_ready = 1 from D+1, so the earliest next accept is at D+1. Throughput is 1 block per NR+2 cycles when out_ready is held high.
- in_ready, out_valid and busy are pure functions of state (registered-state decode), with no combinational path from in_valid or out_ready.
- rd_result is sampled at the same edge it is used; the round unit must close within one cycle.

## Structure
- Package aes_pkg: NR, BW, mode encoding (AES_ENC = 0, AES_DEC = 1), state enum for IDLE/RUN/DONE.
- Sub-module aes_key_sel: combinational mux from round_keys, round and mode to rd_key, covering both forward and reverse indexing.
- The round unit (SubBytes/ShiftRows/MixColumns and inverses plus AddRoundKey) is external and is not part of this block.

## Test plan
- FIPS-197 C.1 vector with the real round unit: key 000102…0f, encrypt 00112233445566778899aabbccddeeff gives out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 cycles after accept.
- Decrypt 69c4e0d86a7b0430d8cdb78070b4c55a with the same key gives 00112233445566778899aabbccddeeff. Check that rd_key walks key10, key9…key0 and that rd_last is high only in round 10.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. out_data stays stable, in_ready = 0, and a second in_valid is not accepted. Release out_ready; the next accept occurs exactly one cycle after the output handshake.
- Back-to-back: encrypt then decrypt with in_valid and out_ready held high gives two correct results 12 cycles apart, and mode does not leak between blocks.
- Reset mid-run: assert rst in round 5. All outputs go to reset values immediately, and no out_valid appears. A new block after reset completes correctly.
- Request in RUN: pulse in_valid with different data in round 3. The result is unaffected, and round and in_ready trace correctly.
